// File: rtl/ysyx_220053_ibus_responder.sv
// Icache refill responder: one 128-bit line per request, fetched as a 2-beat 64-bit burst.
// Optional one-entry line buffer enabled by defining YSYX_220053_IBUS_LINEBUF_EN.
module ysyx_220053_ibus_responder #(
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   i_rw_addr_i,
  input  logic          i_rw_req_i,
  input  logic          i_rw_valid_i,
  output logic [127:0]  i_data_read_o,
  output logic          i_rw_ready_o,
  output logic          mem_ar_valid_o,
  input  logic          mem_ar_ready_i,
  output logic [63:0]   mem_ar_addr_o,
  input  logic          mem_r_valid_i,
  output logic          mem_r_ready_o,
  input  logic [63:0]   mem_r_data_i,
  input  logic          mem_r_last_i,
  input  logic          flush_i,
  output logic          err_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R0   = 3'd2,
    R1   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    addr_q, addr_d;
  logic [127:0]   data_q, data_d;
  logic           err_q, err_d;

  logic [63:0]    line_addr;
  logic           in_range;
  logic           hit;
  logic [127:0]   hit_dat;

  assign line_addr = {i_rw_addr_i[63:4], 4'b0};
  // 65-bit compare so MEM_BASE + MEM_SIZE cannot wrap
  assign in_range  = ({1'b0, line_addr} >= {1'b0, MEM_BASE}) &&
                     ({1'b0, line_addr} <  ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE}));

`ifdef YSYX_220053_IBUS_LINEBUF_EN
  logic           buf_vld_q, buf_vld_d;
  logic [59:0]    buf_tag_q, buf_tag_d;
  logic [127:0]   buf_dat_q, buf_dat_d;
  logic           unused_bits;

  assign unused_bits = ^i_rw_addr_i[3:0];
  assign hit         = buf_vld_q && !flush_i && (buf_tag_q == i_rw_addr_i[63:4]);
  assign hit_dat     = buf_dat_q;

  always_comb begin
    buf_vld_d = buf_vld_q;
    buf_tag_d = buf_tag_q;
    buf_dat_d = buf_dat_q;
    if (state_q == R1 && mem_r_valid_i) begin
      buf_vld_d = 1'b1;
      buf_tag_d = addr_q[63:4];
      buf_dat_d = {mem_r_data_i, data_q[63:0]};
    end
    if (flush_i) begin
      buf_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld_q <= 1'b0;
      buf_tag_q <= '0;
      buf_dat_q <= '0;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_tag_q <= buf_tag_d;
      buf_dat_q <= buf_dat_d;
    end
  end
`else
  logic           unused_bits;

  assign unused_bits = ^{flush_i, i_rw_addr_i[3:0]};
  assign hit         = 1'b0;
  assign hit_dat     = '0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (i_rw_valid_i) begin
          addr_d = line_addr;
          if (i_rw_req_i || !in_range) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (hit) begin
            data_d  = hit_dat;
            state_d = RESP;
          end else begin
            state_d = AR;
          end
        end
      end
      AR: begin
        if (mem_ar_ready_i) begin
          state_d = R0;
        end
      end
      R0: begin
        if (mem_r_valid_i) begin
          data_d[63:0] = mem_r_data_i;
          if (mem_r_last_i) begin
            err_d = 1'b1;
          end
          state_d = R1;
        end
      end
      R1: begin
        if (mem_r_valid_i) begin
          data_d[127:64] = mem_r_data_i;
          if (!mem_r_last_i) begin
            err_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign i_data_read_o  = data_q;
  assign i_rw_ready_o   = (state_q == RESP);
  assign mem_ar_valid_o = (state_q == AR);
  assign mem_ar_addr_o  = addr_q;
  assign mem_r_ready_o  = (state_q == R0) || (state_q == R1);
  assign err_o          = err_q;

endmodule

// File: tb/tb_ysyx_220053_ibus_responder.sv
// Bench for ysyx_220053_ibus_responder: directed vector table, a mid-burst reset sequence,
// and randomized transactions scored against a transaction-level model.
module tb_ysyx_220053_ibus_responder;

  localparam logic [63:0] MB = 64'h8000_0000;
  localparam logic [63:0] MS = 64'h0800_0000;

`ifdef YSYX_220053_IBUS_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   i_rw_addr_i = '0;
  logic          i_rw_req_i = 1'b0;
  logic          i_rw_valid_i = 1'b0;
  logic [127:0]  i_data_read_o;
  logic          i_rw_ready_o;
  logic          mem_ar_valid_o;
  logic          mem_ar_ready_i = 1'b0;
  logic [63:0]   mem_ar_addr_o;
  logic          mem_r_valid_i = 1'b0;
  logic          mem_r_ready_o;
  logic [63:0]   mem_r_data_i = '0;
  logic          mem_r_last_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  ysyx_220053_ibus_responder #(.MEM_BASE(MB), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst(rst),
    .i_rw_addr_i(i_rw_addr_i), .i_rw_req_i(i_rw_req_i), .i_rw_valid_i(i_rw_valid_i),
    .i_data_read_o(i_data_read_o), .i_rw_ready_o(i_rw_ready_o),
    .mem_ar_valid_o(mem_ar_valid_o), .mem_ar_ready_i(mem_ar_ready_i), .mem_ar_addr_o(mem_ar_addr_o),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_ready_o(mem_r_ready_o), .mem_r_data_i(mem_r_data_i),
    .mem_r_last_i(mem_r_last_i), .flush_i(flush_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_pre;
    logic          flush_pre;
    logic          flush;
    logic [63:0]   addr;
    logic          req;
    int            ard;
    int            gap;
    logic [63:0]   b0;
    logic [63:0]   b1;
    logic          l0;
    logic          l1;
    int            exp_lat;
    logic          exp_ar;
    logic [63:0]   exp_ar_addr;
    logic [127:0]  exp_dat;
    logic          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] addr, input logic req, input int ard, input int gap,
                              input logic [63:0] b0, input logic [63:0] b1, input logic l0, input logic l1,
                              input int lat, input logic ar, input logic [127:0] dat, input logic err);
    vec_t v;
    v.rst_pre = 1'b0; v.flush_pre = 1'b0; v.flush = 1'b0;
    v.addr = addr; v.req = req; v.ard = ard; v.gap = gap;
    v.b0 = b0; v.b1 = b1; v.l0 = l0; v.l1 = l1;
    v.exp_lat = lat; v.exp_ar = ar; v.exp_ar_addr = {addr[63:4], 4'b0};
    v.exp_dat = dat; v.exp_err = err;
    return v;
  endfunction

  // Called at posedge+1; leaves the bench at posedge+1 with reset released.
  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic resynced;

  task automatic run_txn(input vec_t v, input string name);
    int ar_cnt, gap_cnt, bi, got;
    logic saw_ar;
    if (v.rst_pre) pulse_reset();
    if (v.flush_pre) begin
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
    end
    i_rw_valid_i = 1'b1;
    i_rw_addr_i  = v.addr;
    i_rw_req_i   = v.req;
    flush_i      = v.flush;
    ar_cnt = 0; gap_cnt = 0; bi = 0; got = -1; saw_ar = 1'b0;
    for (int c = 0; c < 60 && got < 0; c++) begin
      if (c > 0) flush_i = 1'b0;
      mem_ar_ready_i = 1'b0;
      if (mem_ar_valid_o) begin
        mem_ar_ready_i = (ar_cnt >= v.ard);
        ar_cnt++;
      end
      mem_r_valid_i = 1'b0; mem_r_data_i = '0; mem_r_last_i = 1'b0;
      if (mem_r_ready_o && bi < 2) begin
        if (gap_cnt >= ((bi == 0) ? 0 : v.gap)) begin
          mem_r_valid_i = 1'b1;
          mem_r_data_i  = (bi == 0) ? v.b0 : v.b1;
          mem_r_last_i  = (bi == 0) ? v.l0 : v.l1;
          bi++;
          gap_cnt = 0;
        end else begin
          gap_cnt++;
        end
      end
      @(negedge clk);
      if (mem_ar_valid_o) begin
        saw_ar = 1'b1;
        chk({name, " ar_addr"}, {64'h0, mem_ar_addr_o}, {64'h0, v.exp_ar_addr});
      end
      if (i_rw_ready_o) begin
        got = c;
        chk({name, " data"}, i_data_read_o, v.exp_dat);
        chk({name, " err"}, {127'h0, err_o}, {127'h0, v.exp_err});
      end
      @(posedge clk); #1;
    end
    i_rw_valid_i = 1'b0; i_rw_req_i = 1'b0; flush_i = 1'b0;
    mem_ar_ready_i = 1'b0; mem_r_valid_i = 1'b0; mem_r_last_i = 1'b0;
    chk({name, " ready_cycle"}, got, v.exp_lat);
    chk({name, " ar_seen"}, {127'h0, saw_ar}, {127'h0, v.exp_ar});
    @(negedge clk);
    chk({name, " ready_pulse_len"}, {127'h0, i_rw_ready_o}, 128'h0);
    @(posedge clk); #1;
    if (got < 0) begin
      pulse_reset();
      resynced = 1'b1;
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " ready"},  {127'h0, i_rw_ready_o},   128'h0);
    chk({name, " data"},   i_data_read_o,            128'h0);
    chk({name, " ar_vld"}, {127'h0, mem_ar_valid_o}, 128'h0);
    chk({name, " ar_addr"},{64'h0, mem_ar_addr_o},   128'h0);
    chk({name, " r_rdy"},  {127'h0, mem_r_ready_o},  128'h0);
    chk({name, " err"},    {127'h0, err_o},          128'h0);
  endtask

  localparam logic [63:0] B0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] B1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] C0 = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] C1 = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;

  vec_t tbl[14];

  // Transaction-level model state
  logic          m_err;
  logic          m_bv;
  logic [63:0]   m_tag;
  logic [127:0]  m_dat;

  initial begin
    vec_t v;
    logic [63:0]  line;
    logic [64:0]  l65;
    logic         bad;
    int           sel;

    tbl[0]  = mk(64'h8000_0008, 0, 0, 0, B0, B1, 0, 1, 4, 1, {B1, B0}, 0);
    tbl[1]  = mk(64'h8000_0008, 0, 3, 2, B0, B1, 0, 1, 9, 1, {B1, B0}, 0);
    tbl[1].flush = 1'b1;
    if (LB) tbl[2] = mk(64'h8000_0004, 0, 0, 0, C0, C1, 0, 1, 1, 0, {B1, B0}, 0);
    else    tbl[2] = mk(64'h8000_0004, 0, 0, 0, C0, C1, 0, 1, 4, 1, {C1, C0}, 0);
    tbl[3]  = mk(64'h8000_0004, 0, 0, 0, C0, C1, 0, 1, 4, 1, {C1, C0}, 0);
    tbl[3].flush_pre = 1'b1;
    tbl[4]  = mk(64'h87FF_FFFF, 0, 1, 1, D0, D1, 0, 1, 6, 1, {D1, D0}, 0);
    tbl[5]  = mk(64'h8000_0010, 0, 0, 0, B0, B1, 1, 1, 4, 1, {B1, B0}, 1);
    tbl[6]  = mk(64'h8000_0020, 0, 0, 1, C0, C1, 0, 0, 5, 1, {C1, C0}, 1);
    tbl[6].rst_pre = 1'b1;
    tbl[7]  = mk(64'h7FFF_FFF0, 0, 0, 0, B0, B1, 0, 1, 1, 0, 128'h0, 1);
    tbl[7].rst_pre = 1'b1;
    tbl[8]  = mk(64'h8000_0000, 1, 0, 0, B0, B1, 0, 1, 1, 0, 128'h0, 1);
    tbl[9]  = mk(64'h8800_0000, 0, 0, 0, B0, B1, 0, 1, 1, 0, 128'h0, 1);
    tbl[9].rst_pre = 1'b1;
    tbl[10] = mk(64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, B0, B1, 0, 1, 1, 0, 128'h0, 1);
    tbl[10].rst_pre = 1'b1;
    tbl[11] = mk(64'h8000_0040, 0, 2, 0, D1, D0, 0, 1, 6, 1, {D0, D1}, 1);
    tbl[12] = mk(64'h8000_0040, 1, 0, 0, B0, B1, 0, 1, 1, 0, 128'h0, 1);
    if (LB) tbl[13] = mk(64'h8000_0048, 0, 0, 0, B0, B1, 0, 1, 1, 0, {D0, D1}, 1);
    else    tbl[13] = mk(64'h8000_0048, 0, 0, 0, B0, B1, 0, 1, 4, 1, {B1, B0}, 1);

    resynced = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_init");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted while the second beat is pending
    i_rw_valid_i = 1'b1; i_rw_addr_i = 64'h8000_0100; i_rw_req_i = 1'b0;
    @(posedge clk); #1;
    mem_ar_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_ar_ready_i = 1'b0;
    mem_r_valid_i = 1'b1; mem_r_data_i = C0; mem_r_last_i = 1'b0;
    @(posedge clk); #1;
    mem_r_valid_i = 1'b0;
    chk("midrst in_r1", {127'h0, mem_r_ready_o}, 128'h1);
    chk("midrst partial_data_hidden", {127'h0, i_rw_ready_o}, 128'h0);
    rst = 1'b1; i_rw_valid_i = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    mem_r_valid_i = 1'b1; mem_r_data_i = C1; mem_r_last_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stray r_rdy", {127'h0, mem_r_ready_o}, 128'h0);
      chk("stray ready", {127'h0, i_rw_ready_o}, 128'h0);
      @(posedge clk); #1;
    end
    mem_r_valid_i = 1'b0; mem_r_last_i = 1'b0;
    @(negedge clk);
    chk("stray err", {127'h0, err_o}, 128'h0);
    chk("stray data", i_data_read_o, 128'h0);
    @(posedge clk); #1;
    v = mk(64'h8000_0100, 0, 0, 0, D0, B1, 0, 1, 4, 1, {B1, D0}, 0);
    run_txn(v, "after_midrst");

    for (int i = 5; i < 14; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Randomized transactions against the transaction-level model
    pulse_reset();
    m_err = 1'b0; m_bv = 1'b0; m_tag = '0; m_dat = '0;
    for (int n = 0; n < 300; n++) begin
      v.rst_pre   = ($urandom_range(0, 24) == 0);
      v.flush_pre = ($urandom_range(0, 7) == 0);
      v.flush     = ($urandom_range(0, 7) == 0);
      v.req       = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: v.addr = MB + {58'h0, 2'($urandom_range(0, 3)), 4'h0};
        4:          v.addr = MB + MS - 64'h10;
        5:          v.addr = MB - 64'h10;
        6:          v.addr = MB + MS;
        7:          v.addr = 64'hFFFF_FFFF_FFFF_FFF0;
        default:    v.addr = MB + {37'h0, 27'($urandom)};
      endcase
      v.addr[3:0] = 4'($urandom);
      v.ard = $urandom_range(0, 3);
      v.gap = $urandom_range(0, 3);
      v.b0  = {$urandom, $urandom};
      v.b1  = {$urandom, $urandom};
      v.l0  = ($urandom_range(0, 9) == 0);
      v.l1  = ($urandom_range(0, 9) != 0);

      if (v.rst_pre) begin m_err = 1'b0; m_bv = 1'b0; end
      if (v.flush_pre) m_bv = 1'b0;
      line = {v.addr[63:4], 4'h0};
      l65  = {1'b0, line};
      bad  = v.req || (l65 < {1'b0, MB}) || (l65 >= ({1'b0, MB} + {1'b0, MS}));
      v.exp_ar_addr = line;
      if (bad) begin
        v.exp_lat = 1; v.exp_ar = 1'b0; v.exp_dat = '0;
        m_err = 1'b1;
        if (v.flush) m_bv = 1'b0;
      end else if (LB && m_bv && m_tag == line && !v.flush) begin
        v.exp_lat = 1; v.exp_ar = 1'b0; v.exp_dat = m_dat;
      end else begin
        v.exp_lat = 4 + v.ard + v.gap; v.exp_ar = 1'b1; v.exp_dat = {v.b1, v.b0};
        if (v.l0 || !v.l1) m_err = 1'b1;
        m_bv = LB; m_tag = line; m_dat = {v.b1, v.b0};
      end
      v.exp_err = m_err;
      resynced = 1'b0;
      run_txn(v, $sformatf("rand%0d", n));
      if (resynced) begin m_err = 1'b0; m_bv = 1'b0; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_220053_ibus_responder.md
# ysyx_220053_ibus_responder

Memory-side responder for the instruction-cache refill port. Accepts one 128-bit line read request from the icache, performs a 2-beat 64-bit burst read on the downstream read channel, assembles the line, and returns it with a one-cycle ready pulse. It sits between the icache refill interface and the system memory/crossbar read channel.

## Interface

Parameters:
- MEM_BASE, 64'h8000_0000, lowest valid physical address
- MEM_SIZE, 64'h0800_0000, size in bytes of the valid window

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- i_rw_addr_i  in  64  requested address; bits [3:0] ignored
- i_rw_req_i  in  1  0 = read, 1 = write (unsupported)
- i_rw_valid_i  in  1  request valid, held until i_rw_ready_o
- i_data_read_o  out  128  refill line
- i_rw_ready_o  out  1  one-cycle completion pulse
- mem_ar_valid_o  out  1  read-address valid
- mem_ar_ready_i  in  1  read-address accepted
- mem_ar_addr_o  out  64  16-byte-aligned line address
- mem_r_valid_i  in  1  read-data beat valid
- mem_r_ready_o  out  1  read-data accept
- mem_r_data_i  in  64  read-data beat
- mem_r_last_i  in  1  last beat marker
- flush_i  in  1  invalidate line buffer (see Configuration)
- err_o  out  1  sticky protocol/address error

## Operation

- States: IDLE, AR, R0, R1, RESP.
- IDLE: if i_rw_valid_i, latch line address {i_rw_addr_i[63:4],4'b0}.
  - i_rw_req_i=1, or address outside [MEM_BASE, MEM_BASE+MEM_SIZE) (compare in 65 bits, no wrap): data := 0, err_o := 1, -> RESP; no downstream traffic.
  - otherwise -> AR.
- AR: mem_ar_valid_o=1, mem_ar_addr_o = latched line address; hold address stable until mem_ar_ready_i; on handshake -> R0.
- R0: mem_r_ready_o=1; on mem_r_valid_i, data[63:0] := mem_r_data_i; -> R1. mem_r_last_i=1 here sets err_o but the FSM still waits for a second beat.
- R1: mem_r_ready_o=1; on mem_r_valid_i, data[127:64] := mem_r_data_i; -> RESP. mem_r_last_i=0 here sets err_o.
- RESP: i_rw_ready_o=1 for exactly this cycle; -> IDLE.
- i_data_read_o is registered; stable from RESP until the next line write. Never changes while i_rw_ready_o=1.
- Requester drops i_rw_valid_i the cycle after ready; IDLE never accepts in the RESP cycle, so no double acceptance.
- Address/request changes while busy are ignored (latched at acceptance).
- err_o clears only on rst.

## Timing

- Reset values: state IDLE, i_rw_ready_o=0, i_data_read_o=0, mem_ar_valid_o=0, mem_ar_addr_o=0, mem_r_ready_o=0, err_o=0, line buffer invalid.
- Reset mid-transaction aborts immediately; outstanding downstream beats arriving after reset release are ignored (mem_r_ready_o=0 in IDLE).
- Minimum miss latency, zero-wait memory: valid sampled at cycle 0, AR handshake cycle 1, beats cycles 2 and 3, ready at cycle 4.
- Error/write response: ready at cycle 1.
- Downstream stalls extend AR/R0/R1 indefinitely; no timeout.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.

## Configuration

- YSYX_220053_IBUS_LINEBUF_EN defined: one-entry line buffer (tag + valid + 128-bit data) loaded on every successful refill. IDLE read request whose line address equals the valid tag -> RESP directly, ready at cycle 1, no downstream traffic. flush_i=1 clears valid on the next edge; flush in the same cycle as a matching request takes precedence (request treated as miss). Error responses never load the buffer.
- Undefined: no buffer, every read goes downstream; flush_i ignored.

## Test plan

- Read 0x8000_0008, zero-wait memory returning beats 0x1111_2222_3333_4444 then 0x5555_6666_7777_8888 (last on beat 2) -> mem_ar_addr_o=0x8000_0000, ready at cycle 4, i_data_read_o=0x5555_6666_7777_8888_1111_2222_3333_4444, err_o=0.
- Same read with mem_ar_ready_i delayed 3 cycles and 2 idle cycles between beats -> AR address stable throughout, ready at cycle 9, same data.
- Read 0x7FFF_FFF0 and write to 0x8000_0000 -> no mem_ar_valid_o, ready at cycle 1, data 0, err_o=1 sticky until rst.
- mem_r_last_i asserted on beat 1 -> FSM waits for beat 2, completes normally, err_o=1.
- rst pulse while in R1 -> all outputs reset values in the same cycle; a stray beat afterwards is not accepted; next read completes correctly.
- With LINEBUF_EN: repeat read of 0x8000_0004 after refill -> ready at cycle 1, no AR; flush_i then repeat -> full downstream refill, ready at cycle 4.
